coeff_buffer: RTL
=================

// Module: coeff_buffer
// PURPOSE
//   Coefficient store feeding the approximation controller and the polynomial datapath.
//   Loaded once, then read out sequentially, once per evaluation step.
//   Supplies coeff_count_o and start_coeff_o to the controller.
//   Consumes the controller's rd_en_coeff and redo_coeff, and drives the coefficient word into the MAC.
// PARAMETERS
//   DATA_WIDTH  16  coefficient word width (fixed-point, signedness opaque to this block)
//   ADDR_LINES  4   pointer width; capacity DEPTH = 2**ADDR_LINES - 1 entries, so the count fits in ADDR_LINES bits
// PORTS
//   clk_i          in   1           clock
//   rstn_i         in   1           asynchronous, active-low reset
//   clr_i          in   1           synchronous flush; returns block to LOAD
//   wr_en_i        in   1           write strobe (LOAD only)
//   wr_data_i      in   DATA_WIDTH  coefficient; highest order written first
//   commit_i       in   1           end of load; freezes the table
//   rd_en_coeff_i  in   1           advance read pointer, present next coefficient
//   redo_coeff_i   in   1           rewind read pointer to entry 0
//   coeff_o        out  DATA_WIDTH  registered coefficient
//   coeff_valid_o  out  1           coeff_o updated this cycle (1-cycle pulse)
//   coeff_count_o  out  ADDR_LINES  number of committed entries
//   start_coeff_o  out  1           high while READY
//   full_o         out  1           wr_ptr == DEPTH
//   empty_o        out  1           wr_ptr == 0
//   err_o          out  2           sticky {underrun, overflow}; cleared by clr_i or reset only
// BEHAVIOUR
//   Reset: state LOAD; wr_ptr = rd_ptr = 0; coeff_o = 0; coeff_valid_o = 0; coeff_count_o = 0.
//     Reset also forces start_coeff_o = 0, full_o = 0, empty_o = 1, err_o = 0, and acts mid-operation.
//   FSM: LOAD -> READY on commit_i with (wr_ptr != 0, or a write in the same cycle). READY -> LOAD only on clr_i.
//   LOAD: wr_en_i with !full_o stores at wr_ptr and increments wr_ptr.
//     wr_en_i while full_o drops the word and sets err_o[0].
//     commit_i with zero entries is ignored; state stays LOAD, no error.
//     Same-cycle wr_en_i + commit_i: the word is stored and included in the committed count.
//     rd_en_coeff_i in LOAD sets err_o[1]; coeff_o holds.
//   READY: coeff_count_o = wr_ptr (frozen). wr_en_i is dropped and sets err_o[0].
//   Read: rd_en_coeff_i with rd_ptr < coeff_count_o loads mem[rd_ptr] into coeff_o and increments rd_ptr.
//     coeff_valid_o is high the following cycle, so latency is 1 clock from strobe to data.
//     rd_en_coeff_i with rd_ptr == coeff_count_o (exhausted) sets err_o[1]; coeff_o holds; coeff_valid_o stays 0.
//   redo_coeff_i sets rd_ptr = 0 with no output change. It is legal in any state and every cycle.
//   Same-cycle redo + read: the rewind applies first, so mem[0] is output and rd_ptr becomes 1.
//   Priority: rstn_i > clr_i > redo_coeff_i > rd_en_coeff_i; commit_i is evaluated after the write.
//   clr_i zeroes both pointers and err_o. coeff_o holds its last value; coeff_valid_o = 0. Memory contents are not cleared.
//   No pointer wrap: rd_ptr and wr_ptr saturate at DEPTH; all counts are unsigned.
//   Output registers only; no combinational path from any input to any output.
// STRUCTURE
//   Package nla_pkg: DATA_WIDTH/ADDR_LINES defaults; state encoding localparams ST_LOAD, ST_READY; err bit indices.
//   Sub-module coeff_regfile: 1W1R array, DEPTH x DATA_WIDTH, synchronous read, no reset on storage.
//   Top level: FSM, pointers, flags, output registers.
// TESTING
//   1. Write 5,-3,7 then commit -> start_coeff_o = 1, coeff_count_o = 3, empty_o = 0.
//      Then 3 reads -> coeff_o = 5,-3,7, each valid 1 cycle after its strobe.
//   2. After exhausting 3 entries, a 4th read -> err_o = 2'b10, coeff_o stays 7.
//      Then redo + read in the same cycle -> coeff_o = 5, rd_ptr = 1.
//   3. Write 16 words with ADDR_LINES = 4 -> 15 stored, full_o = 1, err_o[0] = 1.
//      Then commit -> coeff_count_o = 15.
//   4. commit_i with nothing written -> remains LOAD, start_coeff_o = 0.
//      Then wr_en_i + commit_i in the same cycle -> READY, count = 1.
//   5. In READY, drive wr_en_i -> err_o[0] set, count unchanged.
//      Then clr_i -> LOAD, err_o = 0, empty_o = 1, coeff_o unchanged.
//   6. Deassert rstn_i mid read sequence -> all outputs go to reset values asynchronously.
//      After release, the block accepts a fresh load.

Source files
------------

// File: rtl/nla_pkg.sv
// rtl/nla_pkg.sv - shared defaults, state encoding and error bit indices for the coefficient buffer
package nla_pkg;

  localparam int NLA_DATA_WIDTH = 16;
  localparam int NLA_ADDR_LINES = 4;

  // The buffer is either accepting a table (LOAD) or serving a frozen one (READY).
  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Bit positions inside the sticky err_o vector.
  localparam int ERR_OVERFLOW = 0;
  localparam int ERR_UNDERRUN = 1;

  // One slot is given up so the entry count still fits in the pointer width.
  function automatic int depth_of(input int addr_lines);
    return (1 << addr_lines) - 1;
  endfunction

endpackage

// File: rtl/coeff_regfile.sv
// rtl/coeff_regfile.sv - 1W1R coefficient array with registered read port
module coeff_regfile
  import nla_pkg::*;
#(
  parameter int DATA_WIDTH = NLA_DATA_WIDTH,
  parameter int ADDR_LINES = NLA_ADDR_LINES
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  wr_en,
  input  logic [ADDR_LINES-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_LINES-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = depth_of(ADDR_LINES);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is never reset; the controller only reads entries it has written.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register doubles as the coefficient output; it holds when no read is issued.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/coeff_buffer.sv
// rtl/coeff_buffer.sv - coefficient store: load, commit, then sequential readout to the MAC
module coeff_buffer
  import nla_pkg::*;
#(
  parameter int DATA_WIDTH = NLA_DATA_WIDTH,
  parameter int ADDR_LINES = NLA_ADDR_LINES
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clr_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  commit_i,
  input  logic                  rd_en_coeff_i,
  input  logic                  redo_coeff_i,
  output logic [DATA_WIDTH-1:0] coeff_o,
  output logic                  coeff_valid_o,
  output logic [ADDR_LINES-1:0] coeff_count_o,
  output logic                  start_coeff_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [1:0]            err_o
);

  localparam int                    DEPTH     = depth_of(ADDR_LINES);
  localparam logic [ADDR_LINES-1:0] DEPTH_PTR = ADDR_LINES'(DEPTH);

  state_e                state_q, state_d;
  logic [ADDR_LINES-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_LINES-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_LINES-1:0] count_d;
  logic [ADDR_LINES-1:0] rd_base;
  logic [1:0]            err_d;
  logic                  valid_d;
  logic                  do_write;
  logic                  do_read;

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, pointer and flag logic; clear beats rewind beats read, commit sees this cycle's write.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = coeff_count_o;
    err_d    = err_o;
    valid_d  = 1'b0;
    do_write = 1'b0;
    do_read  = 1'b0;
    rd_base  = rd_ptr_q;

    if (clr_i) begin
      state_d  = ST_LOAD;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      err_d    = '0;
    end else begin
      if (state_q == ST_LOAD) begin
        if (wr_en_i) begin
          if (wr_ptr_q != DEPTH_PTR) begin
            do_write = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end else begin
            err_d[ERR_OVERFLOW] = 1'b1;
          end
        end
        if (commit_i && (wr_ptr_d != '0)) begin
          state_d = ST_READY;
          count_d = wr_ptr_d;
        end
      end else if (wr_en_i) begin
        err_d[ERR_OVERFLOW] = 1'b1;
      end

      if (redo_coeff_i) begin
        rd_base = '0;
      end
      rd_ptr_d = rd_base;
      if (rd_en_coeff_i) begin
        if ((state_q == ST_READY) && (rd_base < coeff_count_o)) begin
          do_read  = 1'b1;
          valid_d  = 1'b1;
          rd_ptr_d = rd_base + 1'b1;
        end else begin
          err_d[ERR_UNDERRUN] = 1'b1;
        end
      end
    end
  end

  // Pointer and output registers; every output is a flop.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      coeff_count_o <= '0;
      coeff_valid_o <= 1'b0;
      start_coeff_o <= 1'b0;
      full_o        <= 1'b0;
      empty_o       <= 1'b1;
      err_o         <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      coeff_count_o <= count_d;
      coeff_valid_o <= valid_d;
      start_coeff_o <= (state_d == ST_READY);
      full_o        <= (wr_ptr_d == DEPTH_PTR);
      empty_o       <= (wr_ptr_d == '0);
      err_o         <= err_d;
    end
  end

  coeff_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_LINES (ADDR_LINES)
  ) u_regfile (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .wr_en   (do_write),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data_i),
    .rd_en   (do_read),
    .rd_addr (rd_base),
    .rd_data (coeff_o)
  );

endmodule
